// File: rtl/fabric_cfg_pkg.sv
// Shared types and constants for the fabric configuration loader.
// Used by fabric_cfg_loader and cfg_crc8.
package fabric_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_LOAD,
    ST_CHECK,
    ST_DONE,
    ST_ERROR
  } cfg_state_e;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_ABORT = 2'b01;
  localparam logic [1:0] ERR_CRC   = 2'b10;

  localparam logic [7:0] SYNC_WORD_DEF = 8'hA5;
  localparam logic [7:0] CRC8_POLY     = 8'h07;

  // One MSB-first step of the CRC-8 LFSR.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
    logic fb;
    fb = crc[7] ^ din;
    return {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/fabric_cfg_loader_crc8.sv
// Serial CRC-8 LFSR (poly 0x07, init 0x00) with synchronous clear and enable.
// Only instantiated when FABRIC_CFG_CRC_EN is defined.
module cfg_crc8
  import fabric_cfg_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [7:0] crc
);

  logic [7:0] crc_q;
  logic [7:0] crc_d;

  always_comb begin
    crc_d = crc_q;
    if (clr) begin
      crc_d = 8'h00;
    end else if (en) begin
      crc_d = crc8_step(crc_q, din);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q <= 8'h00;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/fabric_cfg_loader.sv
// Sync-framed serial bitstream loader driving CHAINS parallel config chains in lock-step.
// Define FABRIC_CFG_CRC_EN to append and check a CRC-8 trailer after the payload.
module fabric_cfg_loader
  import fabric_cfg_pkg::*;
#(
  parameter int                CHAINS    = 4,
  parameter int                CHAIN_LEN = 64,
  parameter int                SYNC_W    = 8,
  parameter logic [SYNC_W-1:0] SYNC_WORD = SYNC_W'(SYNC_WORD_DEF)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              prog_en,
  input  logic              prog_valid,
  input  logic              prog_in,
  output logic              chain_shift_en,
  output logic [CHAINS-1:0] chain_data,
  output logic              busy,
  output logic              cfg_done,
  output logic              cfg_err,
  output logic [1:0]        err_code,
  output logic              fabric_rst_n
);

  localparam int BW = $clog2(CHAINS) + 1;
  localparam int WW = $clog2(CHAIN_LEN) + 1;
  localparam logic [BW-1:0] BIT_FULL  = BW'(CHAINS);
  localparam logic [WW-1:0] WORD_LAST = WW'(CHAIN_LEN - 1);

  cfg_state_e        state_q, state_d;
  logic              prog_en_q;
  logic [SYNC_W-1:0] sync_q, sync_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [WW-1:0]     word_cnt_q, word_cnt_d;
  logic [CHAINS-1:0] deser_q, deser_d;
  logic [1:0]        err_q, err_d;
  logic              frst_n_q, frst_n_d;
  logic              bit_ok;
  logic              prog_rise;
  logic              strobe;

`ifdef FABRIC_CFG_CRC_EN
  logic       crc_clr;
  logic       crc_en;
  logic [7:0] crc_calc;
  logic [7:0] crc_rx_q, crc_rx_d;
  logic [3:0] crc_cnt_q, crc_cnt_d;

  cfg_crc8 u_crc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (crc_clr),
    .en    (crc_en),
    .din   (prog_in),
    .crc   (crc_calc)
  );
`endif

  assign bit_ok    = prog_valid & prog_en;
  assign prog_rise = prog_en & ~prog_en_q;
  // A full deserialiser word is presented for exactly one cycle, then the count restarts.
  assign strobe    = (state_q == ST_LOAD) && (bit_cnt_q == BIT_FULL);

  always_comb begin
    state_d    = state_q;
    sync_d     = sync_q;
    bit_cnt_d  = bit_cnt_q;
    word_cnt_d = word_cnt_q;
    deser_d    = deser_q;
    err_d      = err_q;
    frst_n_d   = (state_q == ST_DONE);
`ifdef FABRIC_CFG_CRC_EN
    crc_clr   = 1'b0;
    crc_en    = 1'b0;
    crc_rx_d  = crc_rx_q;
    crc_cnt_d = crc_cnt_q;
`endif
    case (state_q)
      ST_SYNC: begin
        if (!prog_en) begin
          state_d = ST_ERROR;
          err_d   = ERR_ABORT;
        end else if (bit_ok) begin
          sync_d = (sync_q << 1) | SYNC_W'(prog_in);
          if (sync_d == SYNC_WORD) begin
            state_d    = ST_LOAD;
            bit_cnt_d  = '0;
            word_cnt_d = '0;
`ifdef FABRIC_CFG_CRC_EN
            crc_clr   = 1'b1;
            crc_cnt_d = '0;
`endif
          end
        end
      end
      ST_LOAD: begin
        if (!prog_en) begin
          state_d = ST_ERROR;
          err_d   = ERR_ABORT;
        end else begin
          if (strobe) begin
            bit_cnt_d  = '0;
            word_cnt_d = word_cnt_q + WW'(1);
          end
          if (strobe && (word_cnt_q == WORD_LAST)) begin
`ifdef FABRIC_CFG_CRC_EN
            // A bit arriving alongside the final strobe is already the first CRC bit.
            state_d = ST_CHECK;
            if (bit_ok) begin
              crc_rx_d  = {crc_rx_q[6:0], prog_in};
              crc_cnt_d = crc_cnt_q + 4'd1;
            end
`else
            state_d = ST_DONE;
`endif
          end else if (bit_ok) begin
            // First-arriving bit of a word ends up on the highest-numbered chain.
            deser_d   = (deser_q << 1) | CHAINS'(prog_in);
            bit_cnt_d = bit_cnt_d + BW'(1);
`ifdef FABRIC_CFG_CRC_EN
            crc_en = 1'b1;
`endif
          end
        end
      end
`ifdef FABRIC_CFG_CRC_EN
      ST_CHECK: begin
        if (!prog_en) begin
          state_d = ST_ERROR;
          err_d   = ERR_ABORT;
        end else if (crc_cnt_q == 4'd8) begin
          if (crc_rx_q == crc_calc) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_ERROR;
            err_d   = ERR_CRC;
          end
        end else if (bit_ok) begin
          crc_rx_d  = {crc_rx_q[6:0], prog_in};
          crc_cnt_d = crc_cnt_q + 4'd1;
        end
      end
`endif
      default: begin
        if (prog_rise) begin
          state_d  = ST_SYNC;
          sync_d   = '0;
          err_d    = ERR_NONE;
          frst_n_d = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      prog_en_q  <= 1'b0;
      sync_q     <= '0;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      deser_q    <= '0;
      err_q      <= ERR_NONE;
      frst_n_q   <= 1'b0;
`ifdef FABRIC_CFG_CRC_EN
      crc_rx_q  <= '0;
      crc_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      prog_en_q  <= prog_en;
      sync_q     <= sync_d;
      bit_cnt_q  <= bit_cnt_d;
      word_cnt_q <= word_cnt_d;
      deser_q    <= deser_d;
      err_q      <= err_d;
      frst_n_q   <= frst_n_d;
`ifdef FABRIC_CFG_CRC_EN
      crc_rx_q  <= crc_rx_d;
      crc_cnt_q <= crc_cnt_d;
`endif
    end
  end

  assign chain_shift_en = strobe;
  assign chain_data     = strobe ? deser_q : '0;
  assign busy           = (state_q == ST_SYNC) || (state_q == ST_LOAD) || (state_q == ST_CHECK);
  assign cfg_done       = (state_q == ST_DONE);
  assign cfg_err        = (state_q == ST_ERROR);
  assign err_code       = err_q;
  assign fabric_rst_n   = frst_n_q;

endmodule

// File: tb/tb_fabric_cfg_loader.sv
// Directed bench for fabric_cfg_loader with CHAINS=4, CHAIN_LEN=4 (16-bit payload 0x1234).
// Strobes and done/reset rises are logged on the falling edge and checked per scenario.
`timescale 1ns/1ps
module tb_fabric_cfg_loader;

  localparam int CH = 4;
  localparam int CL = 4;
`ifdef FABRIC_CFG_CRC_EN
  // CRC-8/poly 0x07/init 0 of bytes 12 34 worked by hand: 0xF1.
  localparam logic [31:0] FRAME = 32'h0012_34F1;
  localparam int          FB    = 24;
`else
  localparam logic [31:0] FRAME = 32'h0000_1234;
  localparam int          FB    = 16;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          prog_en = 1'b0;
  logic          prog_valid = 1'b0;
  logic          prog_in = 1'b0;
  logic          chain_shift_en;
  logic [CH-1:0] chain_data;
  logic          busy;
  logic          cfg_done;
  logic          cfg_err;
  logic [1:0]    err_code;
  logic          fabric_rst_n;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic [CH-1:0] sdata[$];
  int            scyc[$];
  int            drise[$];
  int            rrise[$];
  logic          done_prev = 1'b0;
  logic          rst_prev = 1'b0;

  always #5 clk = ~clk;

  fabric_cfg_loader #(
    .CHAINS    (CH),
    .CHAIN_LEN (CL),
    .SYNC_W    (8),
    .SYNC_WORD (8'hA5)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .prog_en        (prog_en),
    .prog_valid     (prog_valid),
    .prog_in        (prog_in),
    .chain_shift_en (chain_shift_en),
    .chain_data     (chain_data),
    .busy           (busy),
    .cfg_done       (cfg_done),
    .cfg_err        (cfg_err),
    .err_code       (err_code),
    .fabric_rst_n   (fabric_rst_n)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (chain_shift_en === 1'b1) begin
      sdata.push_back(chain_data);
      scyc.push_back(cyc);
    end
    if (cfg_done === 1'b1 && done_prev !== 1'b1) drise.push_back(cyc);
    if (fabric_rst_n === 1'b1 && rst_prev !== 1'b1) rrise.push_back(cyc);
    done_prev <= cfg_done;
    rst_prev  <= fabric_rst_n;
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      prog_valid = 1'b0;
    end
  endtask

  task automatic start_session();
    @(negedge clk);
    prog_en    = 1'b0;
    prog_valid = 1'b0;
    @(negedge clk);
    prog_en = 1'b1;
  endtask

  task automatic send_bits(input logic [31:0] v, input int n, input int gap);
    for (int i = n - 1; i >= 0; i--) begin
      @(negedge clk);
      prog_valid = 1'b1;
      prog_in    = v[i];
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        prog_valid = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (chain_shift_en !== 1'b0) begin bad++; $display("FAIL reset_shift_en: got %b want 0", chain_shift_en); end
    total++; if (chain_data !== 4'h0) begin bad++; $display("FAIL reset_chain_data: got %h want 0", chain_data); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (cfg_done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", cfg_done); end
    total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", cfg_err); end
    total++; if (err_code !== 2'b00) begin bad++; $display("FAIL reset_err_code: got %b want 00", err_code); end
    total++; if (fabric_rst_n !== 1'b0) begin bad++; $display("FAIL reset_fabric_rst_n: got %b want 0", fabric_rst_n); end
    rst_n = 1'b1;
    idle(2);
    $display("test_reset: busy=%b done=%b frst=%b", busy, cfg_done, fabric_rst_n);
  endtask

  task automatic test_nominal();
    int b, db, rb, b2;
    logic [CH-1:0] got;
    b = sdata.size(); db = drise.size(); rb = rrise.size();
    start_session();
    send_bits(32'h0000_00A5, 8, 0);
    send_bits(FRAME, FB, 0);
    idle(4);
    total++; if (sdata.size() - b != 4) begin bad++; $display("FAIL nominal_strobe_count: got %0d want 4", sdata.size() - b); end
    for (int k = 0; k < 4; k++) begin
      got = (b + k < sdata.size()) ? sdata[b + k] : 4'hx;
      total++; if (got !== 4'(k + 1)) begin bad++; $display("FAIL nominal_chain_data_%0d: got %h want %h", k, got, 4'(k + 1)); end
    end
`ifndef FABRIC_CFG_CRC_EN
    total++;
    if (drise.size() != db + 1 || sdata.size() < b + 4) begin
      bad++; $display("FAIL nominal_done_timing: got %0d done rises want 1", drise.size() - db);
    end else if (drise[db] !== scyc[b + 3] + 1) begin
      bad++; $display("FAIL nominal_done_timing: got cycle %0d want %0d", drise[db], scyc[b + 3] + 1);
    end
    total++;
    if (rrise.size() != rb + 1 || drise.size() != db + 1) begin
      bad++; $display("FAIL nominal_frst_timing: got %0d rst rises want 1", rrise.size() - rb);
    end else if (rrise[rb] !== drise[db] + 1) begin
      bad++; $display("FAIL nominal_frst_timing: got cycle %0d want %0d", rrise[rb], drise[db] + 1);
    end
`endif
    total++; if (cfg_done !== 1'b1) begin bad++; $display("FAIL nominal_done: got %b want 1", cfg_done); end
    total++; if (fabric_rst_n !== 1'b1) begin bad++; $display("FAIL nominal_fabric_rst_n: got %b want 1", fabric_rst_n); end
    total++; if (busy !== 1'b0 || cfg_err !== 1'b0 || err_code !== 2'b00) begin bad++; $display("FAIL nominal_flags: got busy=%b err=%b code=%b want 0 0 00", busy, cfg_err, err_code); end
    b2 = sdata.size();
    send_bits(32'h0000_A5A5, 16, 0);
    idle(2);
    total++; if (sdata.size() != b2 || cfg_done !== 1'b1) begin bad++; $display("FAIL nominal_ignore_after_done: got %0d strobes done=%b want 0 strobes done=1", sdata.size() - b2, cfg_done); end
    $display("test_nominal: strobes=%0d done=%b frst=%b", sdata.size() - b, cfg_done, fabric_rst_n);
  endtask

  task automatic test_noise();
    int b, db;
    logic [CH-1:0] got;
    b = sdata.size(); db = drise.size();
    start_session();
    send_bits(32'h0000_00FF, 8, 0);
    send_bits(32'h0000_003A, 8, 0);
    send_bits(32'h0000_00A5, 8, 0);
    total++; if (sdata.size() != b || busy !== 1'b1) begin bad++; $display("FAIL noise_pre_sync: got %0d strobes busy=%b want 0 strobes busy=1", sdata.size() - b, busy); end
    send_bits(FRAME, FB, 0);
    idle(4);
    total++; if (sdata.size() - b != 4) begin bad++; $display("FAIL noise_strobe_count: got %0d want 4", sdata.size() - b); end
    for (int k = 0; k < 4; k++) begin
      got = (b + k < sdata.size()) ? sdata[b + k] : 4'hx;
      total++; if (got !== 4'(k + 1)) begin bad++; $display("FAIL noise_chain_data_%0d: got %h want %h", k, got, 4'(k + 1)); end
    end
`ifndef FABRIC_CFG_CRC_EN
    total++;
    if (drise.size() != db + 1 || sdata.size() < b + 4) begin
      bad++; $display("FAIL noise_done_timing: got %0d done rises want 1", drise.size() - db);
    end else if (drise[db] !== scyc[b + 3] + 1) begin
      bad++; $display("FAIL noise_done_timing: got cycle %0d want %0d", drise[db], scyc[b + 3] + 1);
    end
`endif
    total++; if (cfg_done !== 1'b1 || fabric_rst_n !== 1'b1) begin bad++; $display("FAIL noise_done: got done=%b frst=%b want 1 1", cfg_done, fabric_rst_n); end
    $display("test_noise: strobes=%0d done=%b", sdata.size() - b, cfg_done);
  endtask

  task automatic test_restart();
    int b;
    logic [CH-1:0] got;
    b = sdata.size();
    start_session();
    @(negedge clk);
    total++; if (cfg_done !== 1'b0) begin bad++; $display("FAIL restart_done_clear: got %b want 0", cfg_done); end
    total++; if (fabric_rst_n !== 1'b0) begin bad++; $display("FAIL restart_frst_low: got %b want 0", fabric_rst_n); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL restart_busy: got %b want 1", busy); end
    send_bits(32'h0000_00A5, 8, 1);
    send_bits(FRAME, FB, 1);
    idle(4);
    total++; if (sdata.size() - b != 4) begin bad++; $display("FAIL restart_strobe_count: got %0d want 4", sdata.size() - b); end
    for (int k = 0; k < 4; k++) begin
      got = (b + k < sdata.size()) ? sdata[b + k] : 4'hx;
      total++; if (got !== 4'(k + 1)) begin bad++; $display("FAIL restart_chain_data_%0d: got %h want %h", k, got, 4'(k + 1)); end
    end
    total++; if (cfg_done !== 1'b1 || fabric_rst_n !== 1'b1) begin bad++; $display("FAIL restart_done: got done=%b frst=%b want 1 1", cfg_done, fabric_rst_n); end
    $display("test_restart: strobes=%0d done=%b", sdata.size() - b, cfg_done);
  endtask

  task automatic test_abort();
    int b;
    logic [CH-1:0] got;
    b = sdata.size();
    start_session();
    send_bits(32'h0000_00A5, 8, 0);
    send_bits(FRAME >> (FB - 6), 6, 0);
    @(negedge clk);
    prog_en    = 1'b0;
    prog_valid = 1'b0;
    @(negedge clk);
    total++; if (cfg_err !== 1'b1) begin bad++; $display("FAIL abort_err: got %b want 1", cfg_err); end
    total++; if (err_code !== 2'b01) begin bad++; $display("FAIL abort_err_code: got %b want 01", err_code); end
    total++; if (fabric_rst_n !== 1'b0 || cfg_done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL abort_flags: got frst=%b done=%b busy=%b want 0 0 0", fabric_rst_n, cfg_done, busy); end
    got = (b < sdata.size()) ? sdata[b] : 4'hx;
    total++; if (sdata.size() - b != 1 || got !== 4'h1) begin bad++; $display("FAIL abort_strobes: got %0d strobes first=%h want 1 strobe 1", sdata.size() - b, got); end
    $display("test_abort: err=%b code=%b strobes=%0d", cfg_err, err_code, sdata.size() - b);
  endtask

  task automatic test_sync_abort();
    int b;
    b = sdata.size();
    start_session();
    send_bits(32'h0000_1234, 16, 0);
    idle(2);
    total++; if (sdata.size() != b || busy !== 1'b1) begin bad++; $display("FAIL sync_hold: got %0d strobes busy=%b want 0 strobes busy=1", sdata.size() - b, busy); end
    @(negedge clk);
    prog_en = 1'b0;
    @(negedge clk);
    total++; if (cfg_err !== 1'b1 || err_code !== 2'b01) begin bad++; $display("FAIL sync_abort: got err=%b code=%b want 1 01", cfg_err, err_code); end
    send_bits(32'h0000_00A5, 8, 0);
    send_bits(FRAME, FB, 0);
    idle(3);
    total++; if (sdata.size() != b || busy !== 1'b0 || cfg_err !== 1'b1) begin bad++; $display("FAIL valid_ignored_when_disabled: got %0d strobes busy=%b err=%b want 0 0 1", sdata.size() - b, busy, cfg_err); end
    $display("test_sync_abort: err=%b code=%b", cfg_err, err_code);
  endtask

`ifdef FABRIC_CFG_CRC_EN
  task automatic test_crc();
    int b;
    start_session();
    send_bits(32'h0000_00A5, 8, 0);
    send_bits(FRAME, FB, 0);
    idle(4);
    total++; if (cfg_done !== 1'b1 || cfg_err !== 1'b0) begin bad++; $display("FAIL crc_good: got done=%b err=%b want 1 0", cfg_done, cfg_err); end
    b = sdata.size();
    start_session();
    send_bits(32'h0000_00A5, 8, 0);
    send_bits(FRAME ^ 32'h1, FB, 0);
    idle(4);
    total++; if (cfg_err !== 1'b1 || err_code !== 2'b10) begin bad++; $display("FAIL crc_bad: got err=%b code=%b want 1 10", cfg_err, err_code); end
    total++; if (fabric_rst_n !== 1'b0 || cfg_done !== 1'b0) begin bad++; $display("FAIL crc_bad_flags: got frst=%b done=%b want 0 0", fabric_rst_n, cfg_done); end
    total++; if (sdata.size() - b != 4) begin bad++; $display("FAIL crc_bad_strobes: got %0d want 4", sdata.size() - b); end
    $display("test_crc: err=%b code=%b", cfg_err, err_code);
  endtask
`endif

  task automatic test_rst_mid();
    int b;
    b = sdata.size();
    start_session();
    send_bits(32'h0000_00A5, 8, 0);
    send_bits(FRAME >> (FB - 5), 5, 0);
    total++; if (chain_shift_en !== 1'b1 || chain_data !== 4'h1) begin bad++; $display("FAIL rst_mid_pre_strobe: got en=%b data=%h want 1 1", chain_shift_en, chain_data); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (chain_shift_en !== 1'b0 || chain_data !== 4'h0) begin bad++; $display("FAIL rst_mid_chain: got en=%b data=%h want 0 0", chain_shift_en, chain_data); end
    total++; if (busy !== 1'b0 || cfg_done !== 1'b0 || cfg_err !== 1'b0 || err_code !== 2'b00 || fabric_rst_n !== 1'b0) begin
      bad++; $display("FAIL rst_mid_outputs: got busy=%b done=%b err=%b code=%b frst=%b want all 0", busy, cfg_done, cfg_err, err_code, fabric_rst_n);
    end
    prog_en    = 1'b0;
    prog_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    total++; if (busy !== 1'b0 || cfg_err !== 1'b0) begin bad++; $display("FAIL rst_mid_idle: got busy=%b err=%b want 0 0", busy, cfg_err); end
    b = sdata.size();
    start_session();
    send_bits(32'h0000_00A5, 8, 0);
    send_bits(FRAME, FB, 0);
    idle(4);
    total++; if (sdata.size() - b != 4 || cfg_done !== 1'b1 || fabric_rst_n !== 1'b1) begin
      bad++; $display("FAIL rst_mid_reload: got %0d strobes done=%b frst=%b want 4 1 1", sdata.size() - b, cfg_done, fabric_rst_n);
    end
    $display("test_rst_mid: strobes=%0d done=%b", sdata.size() - b, cfg_done);
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_noise();
    test_restart();
    test_abort();
    test_sync_abort();
`ifdef FABRIC_CFG_CRC_EN
    test_crc();
`endif
    test_rst_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
